vga_anim_sequencer: RTL and testbench
=====================================

# vga_anim_sequencer

Frame-synchronous animation and configuration controller for the VGA layer-pattern datapath. Detects the start of each frame from the timing generator's `vsync` in the pixel clock domain, then advances a wrap-around animation phase by a user-selected speed and direction. Player inputs (`ui_in`) are synchronised and applied only at frame boundaries, so the pattern never tears mid-frame. Outputs feed the datapath's horizontal offset (`phase`) and active-layer limit (`layers`). This replaces the `posedge vsync`-clocked counter with a single-clock design.

## Interface

Clock is `clk`; reset is `rst_n`, asynchronous, active-low.

Parameters:
- `PHASE_W`, default 10: width of the animation phase.
- `LAYERS_RST`, default 63: value of `layers` after reset.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `vsync`  in  1  from `hvsync_generator`, synchronous to `clk`. Active-high pulse.
- `cfg_speed`  in  3  phase increment minus 1. Asynchronous pin.
- `cfg_dir`  in  1  0 = phase increments, 1 = phase decrements. Asynchronous.
- `cfg_pause`  in  1  level; 1 requests pause. Asynchronous.
- `cfg_step`  in  1  in pause, a rising edge requests one frame advance. Asynchronous.
- `cfg_layers`  in  6  highest enabled layer index. Asynchronous.
- `phase`  out  PHASE_W  animation phase.
- `layers`  out  6  applied layer limit.
- `frame_tick`  out  1  one-cycle pulse per frame boundary.
- `paused`  out  1  1 when the FSM is in PAUSE or STEP.

## Operation

- **Input synchronisers.** Every `cfg_*` input passes through a 2-flop synchroniser. All later logic uses only the synchronised copies, written `s_*` below.
- **Step edge detect.** `step_req` is 1 when `s_step` is 1 and its previous sample was 0. It lasts one cycle.
- **Frame edge.** `vsync_q` is `vsync` registered once. `fe = vsync & ~vsync_q`. Exactly one `fe` occurs per `vsync` high pulse, whatever the pulse length.
- **Increment.** `inc = s_speed + 1`, range 1..8, zero-extended to PHASE_W.
- **Phase update.** On an advancing `fe`:
  - if `s_dir` = 0: `phase <= phase + inc`;
  - if `s_dir` = 1: `phase <= phase - inc`.
  - Both are modulo 2^PHASE_W: 1023 + 1 wraps to 0, and 0 − 1 wraps to 1023.
- **Layer update.** `layers <= s_layers` on every `fe`, including in PAUSE. Between frame edges, `layers` holds.
- **FSM states:** RUN, PAUSE, STEP. Transitions are evaluated every cycle.
  - RUN: on `fe`, advance the phase. If `s_pause` = 1, go to PAUSE on the same edge; the phase still advances on that frame.
  - PAUSE: on `fe`, no advance. If `s_pause` = 0, go to RUN; the first advance happens at the next `fe`. If `step_req` = 1, go to STEP.
  - STEP: on `fe`, advance exactly once. Then go to PAUSE if `s_pause` = 1, else to RUN.
  - Simultaneous `step_req` and `fe` in PAUSE: go to STEP with no advance this frame; the advance happens on the following `fe`.
  - `step_req` while in RUN or STEP is ignored; no queueing.
  - `s_pause` falling while in STEP: the pending step still executes, then go to RUN.
- **Reset** (asynchronous, any time, including mid-frame):
  - `phase` = 0, `layers` = LAYERS_RST, `frame_tick` = 0, `paused` = 0;
  - state = RUN, `vsync_q` = 0, all synchroniser flops = 0.
- **Edge case after reset release.** If `vsync` is already high at release, an `fe` occurs on the first clock. This is acceptable.

## Timing

- **Frame edge to outputs.** Take the clock edge at which `vsync` is first sampled 1 as edge N.
  - `frame_tick`, `phase` and `layers` all update at edge N+1.
  - `frame_tick` is high for exactly one cycle.
- **Config latency.** A `cfg_*` pin change is visible in `s_*` after 2 clock edges. A change must be stable at least 3 cycles before edge N to take effect on that frame.
- **`paused`.** Registered; reflects the state after each clock edge.
- **Register map.** All outputs are driven directly from flops, with no combinational path from inputs to outputs.
- **Throughput.** One phase advance at most per `fe`. `fe` may recur as often as every 2 cycles (pulse-width-1 `vsync`); the design must handle this.

## Test plan

- **Reset then run.** Hold `rst_n` = 0, then release. Apply 3 `vsync` pulses with speed=0, dir=0, pause=0. Expect `phase` = 0 → 1 → 2 → 3, each change at edge N+1 with a single-cycle `frame_tick`, and `layers` = 63.
- **Wrap-around.** Set speed=7, dir=0 with phase at 1020. One frame gives 4. Then set dir=1 and run one frame: 4 → 1020.
- **Pause and step.**
  - Assert pause: the frame on which pause is first seen still advances (5 → 6), and `paused` = 1.
  - Two further frames: `phase` stays 6.
  - Pulse `cfg_step`: the next frame gives 7; the frame after holds at 7.
  - Deassert pause: the next frame gives 8.
- **Layer shadowing.** Change `cfg_layers` from 63 to 12 mid-frame. `layers` stays 63 until the next `frame_tick`, then becomes 12. This also applies while paused.
- **Reset mid-operation.** With `phase` = 300, in PAUSE and `layers` = 12, pulse `rst_n` low between clock edges. All outputs return to reset values immediately, without waiting for a clock edge. The next frame yields `phase` = 1.
- **Long vsync and step corner.**
  - A 50-cycle `vsync` pulse produces exactly one `frame_tick`.
  - `step_req` coincident with `fe` in PAUSE: no advance on that frame, exactly +1 on the next.

Source files
------------

// File: rtl/vga_anim_sequencer.sv
// rtl/vga_anim_sequencer.sv - frame-synchronous animation phase and layer-limit controller
// Single-clock replacement for the vsync-clocked counter; config is applied only at frame edges.
module vga_anim_sequencer #(
  parameter int         PHASE_W    = 10,
  parameter logic [5:0] LAYERS_RST = 6'd63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic [2:0]         cfg_speed,
  input  logic               cfg_dir,
  input  logic               cfg_pause,
  input  logic               cfg_step,
  input  logic [5:0]         cfg_layers,
  output logic [PHASE_W-1:0] phase,
  output logic [5:0]         layers,
  output logic               frame_tick,
  output logic               paused
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2:0] speed_m, speed_s;
  logic       dir_m, dir_s;
  logic       pause_m, pause_s;
  logic       step_m, step_s, step_prev;
  logic [5:0] layers_m, layers_s;

  logic vsync_q;
  logic fe;
  logic fe_q;
  logic step_req;
  logic advance;
  logic [PHASE_W-1:0] inc;

  // Two-flop synchronisers on every asynchronous configuration pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_m   <= '0;
      speed_s   <= '0;
      dir_m     <= 1'b0;
      dir_s     <= 1'b0;
      pause_m   <= 1'b0;
      pause_s   <= 1'b0;
      step_m    <= 1'b0;
      step_s    <= 1'b0;
      step_prev <= 1'b0;
      layers_m  <= '0;
      layers_s  <= '0;
    end else begin
      speed_m   <= cfg_speed;
      speed_s   <= speed_m;
      dir_m     <= cfg_dir;
      dir_s     <= dir_m;
      pause_m   <= cfg_pause;
      pause_s   <= pause_m;
      step_m    <= cfg_step;
      step_s    <= step_m;
      step_prev <= step_s;
      layers_m  <= cfg_layers;
      layers_s  <= layers_m;
    end
  end

  assign step_req = step_s & ~step_prev;
  assign fe       = vsync & ~vsync_q;
  assign inc      = PHASE_W'({1'b0, speed_s} + 4'd1);

  // fe is registered so every output moves one edge after vsync is first sampled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      fe_q    <= fe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      RUN: begin
        if (fe_q) begin
          advance = 1'b1;
          if (pause_s) next_state = PAUSE;
        end
      end
      PAUSE: begin
        // A step coincident with a frame edge defers its advance to the following edge.
        if (step_req)      next_state = STEP;
        else if (!pause_s) next_state = RUN;
      end
      STEP: begin
        if (fe_q) begin
          advance    = 1'b1;
          next_state = pause_s ? PAUSE : RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      layers     <= LAYERS_RST;
      frame_tick <= 1'b0;
      paused     <= 1'b0;
    end else begin
      frame_tick <= fe_q;
      paused     <= (next_state != RUN);
      if (fe_q) layers <= layers_s;
      if (advance) phase <= dir_s ? (phase - inc) : (phase + inc);
    end
  end

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// tb/tb_vga_anim_sequencer.sv - table-driven scoreboard bench for vga_anim_sequencer
// Expected per-frame outputs are queued before each vsync and compared on every frame_tick.
module tb_vga_anim_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic [2:0] cfg_speed = 3'd0;
  logic       cfg_dir = 1'b0;
  logic       cfg_pause = 1'b0;
  logic       cfg_step = 1'b0;
  logic [5:0] cfg_layers = 6'd63;
  logic [9:0] phase;
  logic [5:0] layers;
  logic       frame_tick;
  logic       paused;

  vga_anim_sequencer #(.PHASE_W(10), .LAYERS_RST(6'd63)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .cfg_speed  (cfg_speed),
    .cfg_dir    (cfg_dir),
    .cfg_pause  (cfg_pause),
    .cfg_step   (cfg_step),
    .cfg_layers (cfg_layers),
    .phase      (phase),
    .layers     (layers),
    .frame_tick (frame_tick),
    .paused     (paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int ly;
    int pz;
  } exp_t;

  typedef struct {
    logic [2:0] speed;
    logic       dir;
    logic       pause;
    logic       step;
    logic [5:0] lay;
    int         ph;
    int         ly;
    int         pz;
  } vec_t;

  exp_t q[$];
  vec_t vecs[14];
  int checks = 0;
  int fails = 0;
  int ticks = 0;
  int pushes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input int ph, input int ly, input int pz);
    exp_t e;
    e.ph = ph;
    e.ly = ly;
    e.pz = pz;
    q.push_back(e);
    pushes++;
  endtask

  task automatic frame(input int width);
    @(posedge clk); #1 vsync = 1'b1;
    repeat (width) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_tick) begin
      exp_t e;
      ticks++;
      if (q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = q.pop_front();
        check("tick_phase", int'(phase), e.ph);
        check("tick_layers", int'(layers), e.ly);
        check("tick_paused", int'(paused), e.pz);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 6'd63, 1,    63, 0};
    vecs[1]  = '{3'd0, 1'b0, 1'b0, 1'b0, 6'd63, 2,    63, 0};
    vecs[2]  = '{3'd0, 1'b0, 1'b0, 1'b0, 6'd63, 3,    63, 0};
    vecs[3]  = '{3'd6, 1'b1, 1'b0, 1'b0, 6'd63, 1020, 63, 0};
    vecs[4]  = '{3'd7, 1'b0, 1'b0, 1'b0, 6'd63, 4,    63, 0};
    vecs[5]  = '{3'd7, 1'b1, 1'b0, 1'b0, 6'd63, 1020, 63, 0};
    vecs[6]  = '{3'd7, 1'b0, 1'b0, 1'b0, 6'd63, 4,    63, 0};
    vecs[7]  = '{3'd0, 1'b0, 1'b0, 1'b0, 6'd63, 5,    63, 0};
    vecs[8]  = '{3'd0, 1'b0, 1'b1, 1'b0, 6'd63, 6,    63, 1};
    vecs[9]  = '{3'd0, 1'b0, 1'b1, 1'b0, 6'd63, 6,    63, 1};
    vecs[10] = '{3'd0, 1'b0, 1'b1, 1'b0, 6'd12, 6,    12, 1};
    vecs[11] = '{3'd0, 1'b0, 1'b1, 1'b1, 6'd12, 7,    12, 1};
    vecs[12] = '{3'd0, 1'b0, 1'b1, 1'b0, 6'd12, 7,    12, 1};
    vecs[13] = '{3'd0, 1'b0, 1'b0, 1'b0, 6'd12, 8,    12, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_layers", int'(layers), 63);
    check("rst_frame_tick", int'(frame_tick), 0);
    check("rst_paused", int'(paused), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      #1;
      cfg_speed  = vecs[i].speed;
      cfg_dir    = vecs[i].dir;
      cfg_pause  = vecs[i].pause;
      cfg_step   = vecs[i].step;
      cfg_layers = vecs[i].lay;
      repeat (6) @(posedge clk);
      expect_frame(vecs[i].ph, vecs[i].ly, vecs[i].pz);
      frame(1);
    end

    // Exact edge timing: nothing moves at edge N, everything at N+1, tick lasts one cycle.
    expect_frame(9, 12, 0);
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1;
    check("edgeN_tick", int'(frame_tick), 0);
    check("edgeN_phase", int'(phase), 8);
    vsync = 1'b0;
    @(posedge clk); #1;
    check("edgeN1_tick", int'(frame_tick), 1);
    check("edgeN1_phase", int'(phase), 9);
    @(posedge clk); #1;
    check("edgeN2_tick", int'(frame_tick), 0);
    repeat (4) @(posedge clk);

    // Mid-frame layer change is held until the next frame tick.
    #1 cfg_layers = 6'd63;
    repeat (10) @(posedge clk);
    #1 check("shadow_hold", int'(layers), 12);
    expect_frame(10, 63, 0);
    frame(1);

    t0 = ticks;
    expect_frame(11, 63, 0);
    frame(50);
    check("long_vsync_ticks", ticks - t0, 1);

    #1 cfg_pause = 1'b1;
    cfg_layers = 6'd12;
    repeat (6) @(posedge clk);
    expect_frame(12, 12, 1);
    frame(1);

    // Step request lands in the same cycle as the registered frame edge.
    @(posedge clk); #1 cfg_step = 1'b1;
    expect_frame(12, 12, 1);
    frame(1);
    #1 cfg_step = 1'b0;
    repeat (4) @(posedge clk);
    expect_frame(13, 12, 1);
    frame(1);
    repeat (4) @(posedge clk);
    #1 check("corner_paused", int'(paused), 1);

    @(posedge clk); #2 rst_n = 1'b0;
    cfg_pause = 1'b0;
    #1;
    check("async_rst_phase", int'(phase), 0);
    check("async_rst_layers", int'(layers), 63);
    check("async_rst_paused", int'(paused), 0);
    check("async_rst_tick", int'(frame_tick), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    expect_frame(1, 12, 0);
    frame(1);

    repeat (5) @(posedge clk);
    check("queue_empty", q.size(), 0);
    check("tick_count", ticks, pushes);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
